pll_lock_sequencer: RTL

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: PLL reset pulse, lock wait, stability qualification, run monitoring.
// Optional macro PLL_LOCK_TIMEOUT_EN enables the lock timeout with retries and the FAULT state.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       domain_rst,
    output logic       fault,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic [7:0] lost_lock_cnt
);

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES
                                                                      : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t        fsm;
    logic [CW-1:0] cnt;
    logic          locked_meta;
    logic          locked_s;

    assign state = fsm;

    // Outputs are updated together with the state transition so they stay registered.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_meta   <= 1'b0;
            locked_s      <= 1'b0;
            fsm           <= PLL_RST;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            domain_rst    <= 1'b1;
            fault         <= 1'b0;
            retry_cnt     <= '0;
            lost_lock_cnt <= '0;
        end else begin
            locked_meta <= pll_locked;
            locked_s    <= locked_meta;
            if (restart_req) begin
                fsm        <= PLL_RST;
                cnt        <= '0;
                retry_cnt  <= '0;
                fault      <= 1'b0;
                pll_rst    <= 1'b1;
                domain_rst <= 1'b1;
            end else begin
                case (fsm)
                    PLL_RST: begin
                        if (cnt == RST_LAST) begin
                            fsm     <= WAIT_LOCK;
                            cnt     <= '0;
                            pll_rst <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    WAIT_LOCK: begin
                        if (locked_s) begin
                            fsm <= STABILIZE;
                            cnt <= '0;
                        end else if (TIMEOUT_EN) begin
                            if (cnt == TIMEOUT_LAST) begin
                                cnt     <= '0;
                                pll_rst <= 1'b1;
                                if (retry_cnt < RETRY_LIMIT) begin
                                    retry_cnt <= retry_cnt + 4'd1;
                                    fsm       <= PLL_RST;
                                end else begin
                                    fsm   <= FAULT;
                                    fault <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    STABILIZE: begin
                        if (!locked_s) begin
                            fsm <= WAIT_LOCK;
                            cnt <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            fsm        <= RUN;
                            cnt        <= '0;
                            domain_rst <= 1'b0;
                            retry_cnt  <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    RUN: begin
                        if (!locked_s) begin
                            fsm        <= PLL_RST;
                            cnt        <= '0;
                            pll_rst    <= 1'b1;
                            domain_rst <= 1'b1;
                            if (lost_lock_cnt != '1)
                                lost_lock_cnt <= lost_lock_cnt + 8'd1;
                        end
                    end
                    FAULT: begin
                        fsm <= FAULT;
                    end
                    default: begin
                        fsm        <= PLL_RST;
                        cnt        <= '0;
                        pll_rst    <= 1'b1;
                        domain_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
